// File: rtl/aes_pkg.sv
// Shared constants, round-constant table, S-box and FSM encoding for the
// AES-128 key schedule controller.
package aes_pkg;

  localparam int KEY_W      = 128;
  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  // Entry 0 is unused; round r uses RCON[r] in the top byte of the word.
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step: derives round key r from round key r-1.
module aes_key_round
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] prev_key,
  input  logic [7:0]       rcon,
  output logic [KEY_W-1:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key;

  // RotWord then SubWord on the last word, then fold in the round constant.
  assign temp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: expands one round key per cycle into an
// 11-entry store and serves registered round-key reads.
module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [aes_pkg::KEY_W-1:0] key_in,
  input  logic                      key_load,
  output logic                      load_ready,
  output logic                      busy,
  output logic                      keys_valid,
  input  logic                      rd_en,
  input  logic [3:0]                rd_round,
  output logic [aes_pkg::KEY_W-1:0] rd_key,
  output logic                      rd_valid,
  output logic                      rd_err
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t           state, state_n;
  logic [3:0]       cnt;
  logic [KEY_W-1:0] rk [0:NUM_ROUNDS];
  logic [KEY_W-1:0] next_key;
  logic             accept;
  logic             expanding;
  logic             last_step;

  assign load_ready = (state == ST_IDLE) || (state == ST_READY);
  assign busy       = (state == ST_EXPAND);
  assign accept     = key_load && load_ready && !reset;
  assign expanding  = (state == ST_EXPAND) && !reset;
  assign last_step  = (cnt == LAST_ROUND);

  aes_key_round u_round (
    .prev_key (rk[cnt - 4'd1]),
    .rcon     (RCON[cnt]),
    .next_key (next_key)
  );

  always_comb begin
    // NOTE: default first so every path assigns state_n and no latch is inferred.
    state_n = state;
    unique case (state)
      ST_IDLE, ST_READY: if (key_load) state_n = ST_EXPAND;
      ST_EXPAND:         if (last_step) state_n = ST_READY;
      default:           state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 4'd0;
      keys_valid <= 1'b0;
    end else if (accept) begin
      cnt        <= 4'd1;
      keys_valid <= 1'b0;
    end else if (expanding) begin
      cnt <= cnt + 4'd1;
      if (last_step) keys_valid <= 1'b1;
    end
  end

  // NOTE: the key store is not reset; keys_valid gates every read of it.
  always_ff @(posedge clk) begin
    if (accept)         rk[0]   <= key_in;
    else if (expanding) rk[cnt] <= next_key;
  end

  // Reads sample rk before this edge's writes, so a read coinciding with a
  // reload returns the old key set.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_key   <= '0;
    end else if (rd_en) begin
      rd_valid <= 1'b1;
      if (keys_valid && (rd_round <= LAST_ROUND)) begin
        rd_key <= rk[rd_round];
        rd_err <= 1'b0;
      end else begin
        rd_key <= '0;
        rd_err <= 1'b1;
      end
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using FIPS-197 key-expansion vectors.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_A_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_Z    = 128'h0;
  localparam logic [127:0] KEY_Z_R1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KEY_Z_RA = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] key_in;
  logic         key_load;
  logic         load_ready;
  logic         busy;
  logic         keys_valid;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic         rd_err;

  int n_cmp = 0;
  int n_mis = 0;

  aes_key_sched_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_load   (key_load),
    .load_ready (load_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_en      (rd_en),
    .rd_round   (rd_round),
    .rd_key     (rd_key),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic read_round(input logic [3:0] r);
    rd_en    = 1'b1;
    rd_round = r;
    tick();
    rd_en    = 1'b0;
  endtask

  // Runs edges after an accept until keys_valid rises (bounded). Optionally
  // pulses a zero-key load before edge glitch_at and a read before edge rd_at.
  task automatic run_expand(input int glitch_at, input int rd_at, output int cycles);
    cycles = 0;
    while (cycles < 20) begin
      key_load = (cycles + 1 == glitch_at);
      key_in   = (cycles + 1 == glitch_at) ? KEY_Z : key_in;
      rd_en    = (cycles + 1 == rd_at);
      rd_round = 4'd1;
      tick();
      cycles++;
      if (cycles == rd_at) begin
        check("expand_rd_valid", 128'(rd_valid), 128'd1);
        check("expand_rd_err", 128'(rd_err), 128'd1);
        check("expand_rd_key", rd_key, 128'd0);
      end
      if (keys_valid) break;
    end
    key_load = 1'b0;
    rd_en    = 1'b0;
  endtask

  int cyc;

  initial begin
    reset    = 1'b1;
    key_in   = '0;
    key_load = 1'b0;
    rd_en    = 1'b0;
    rd_round = 4'd0;
    tick();
    tick();

    check("rst_load_ready", 128'(load_ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_keys_valid", 128'(keys_valid), 128'd0);
    check("rst_rd_valid", 128'(rd_valid), 128'd0);
    check("rst_rd_err", 128'(rd_err), 128'd0);
    check("rst_rd_key", rd_key, 128'd0);
    reset = 1'b0;

    // Read before any keys exist is rejected; error flag holds afterward.
    read_round(4'd0);
    check("idle_rd_valid", 128'(rd_valid), 128'd1);
    check("idle_rd_err", 128'(rd_err), 128'd1);
    tick();
    check("idle_rd_valid_drop", 128'(rd_valid), 128'd0);
    check("idle_rd_err_hold", 128'(rd_err), 128'd1);

    // First expansion, with a rejected read in the middle.
    load_key(KEY_A);
    check("acc_busy", 128'(busy), 128'd1);
    check("acc_load_ready", 128'(load_ready), 128'd0);
    check("acc_keys_valid", 128'(keys_valid), 128'd0);
    run_expand(0, 4, cyc);
    check("a_latency", 128'(cyc), 128'd10);
    check("a_busy_done", 128'(busy), 128'd0);
    check("a_load_ready", 128'(load_ready), 128'd1);

    read_round(4'd1);
    check("a_r1_valid", 128'(rd_valid), 128'd1);
    check("a_r1_err", 128'(rd_err), 128'd0);
    check("a_r1_key", rd_key, KEY_A_R1);

    // Back-to-back reads, then hold.
    rd_en = 1'b1; rd_round = 4'd0;
    tick();
    check("b2b_r0_valid", 128'(rd_valid), 128'd1);
    check("b2b_r0_key", rd_key, KEY_A);
    rd_round = 4'd10;
    tick();
    rd_en = 1'b0;
    check("b2b_r10_valid", 128'(rd_valid), 128'd1);
    check("b2b_r10_key", rd_key, KEY_A_RA);
    tick();
    check("hold_valid", 128'(rd_valid), 128'd0);
    check("hold_key", rd_key, KEY_A_RA);
    check("hold_err", 128'(rd_err), 128'd0);

    // Out-of-range indices.
    read_round(4'd11);
    check("r11_valid", 128'(rd_valid), 128'd1);
    check("r11_err", 128'(rd_err), 128'd1);
    check("r11_key", rd_key, 128'd0);
    read_round(4'd15);
    check("r15_err", 128'(rd_err), 128'd1);

    // Reload in READY with a simultaneous read: old key set returned.
    key_in = KEY_Z; key_load = 1'b1; rd_en = 1'b1; rd_round = 4'd10;
    tick();
    key_load = 1'b0; rd_en = 1'b0;
    check("rl_rd_key", rd_key, KEY_A_RA);
    check("rl_rd_err", 128'(rd_err), 128'd0);
    check("rl_keys_valid", 128'(keys_valid), 128'd0);
    check("rl_busy", 128'(busy), 128'd1);
    run_expand(0, 0, cyc);
    check("z_latency", 128'(cyc), 128'd10);
    read_round(4'd10);
    check("z_r10_key", rd_key, KEY_Z_RA);
    read_round(4'd1);
    check("z_r1_key", rd_key, KEY_Z_R1);

    // key_load during EXPAND is ignored.
    load_key(KEY_A);
    run_expand(3, 0, cyc);
    check("ign_latency", 128'(cyc), 128'd10);
    read_round(4'd10);
    check("ign_r10_key", rd_key, KEY_A_RA);
    read_round(4'd0);
    check("ign_r0_key", rd_key, KEY_A);

    // Reset mid-expansion, with load and read also asserted.
    load_key(KEY_Z);
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy", 128'(busy), 128'd1);
    reset = 1'b1; key_load = 1'b1; key_in = KEY_A; rd_en = 1'b1; rd_round = 4'd0;
    tick();
    reset = 1'b0; key_load = 1'b0; rd_en = 1'b0;
    check("mrst_busy", 128'(busy), 128'd0);
    check("mrst_keys_valid", 128'(keys_valid), 128'd0);
    check("mrst_load_ready", 128'(load_ready), 128'd1);
    check("mrst_rd_valid", 128'(rd_valid), 128'd0);
    check("mrst_rd_key", rd_key, 128'd0);
    tick();
    check("mrst_still_idle", 128'(busy), 128'd0);

    load_key(KEY_A);
    run_expand(0, 0, cyc);
    check("post_latency", 128'(cyc), 128'd10);
    read_round(4'd10);
    check("post_r10_key", rd_key, KEY_A_RA);
    read_round(4'd1);
    check("post_r1_key", rd_key, KEY_A_R1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10: number of expanded rounds; only 10 (AES-128) is supported.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 SHALL have port key_in  input  128  cipher key, byte 0 in [127:120].
REQ-005 SHALL have port key_load  input  1  load request, sampled with key_in.
REQ-006 SHALL have port load_ready  output  1  high when a load will be accepted.
REQ-007 SHALL have port busy  output  1  high while expansion is in progress.
REQ-008 SHALL have port keys_valid  output  1  high when all 11 round keys are stored and stable.
REQ-009 SHALL have port rd_en  input  1  round-key read request.
REQ-010 SHALL have port rd_round  input  4  round index 0..10.
REQ-011 SHALL have port rd_key  output  128  registered read data.
REQ-012 SHALL have port rd_valid  output  1  rd_key valid this cycle.
REQ-013 SHALL have port rd_err  output  1  read rejected (bad index or keys not valid).

Function
REQ-014 SHALL implement FSM states IDLE, EXPAND, READY.
REQ-015 SHALL accept a load on a rising edge where key_load=1 and load_ready=1; load_ready = (state is IDLE or READY).
REQ-016 On accept: rk[0] <= key_in, round counter <= 1, state <= EXPAND, keys_valid <= 0.
REQ-017 In EXPAND, each edge: rk[cnt] <= next_key(rk[cnt-1], rcon[cnt]), cnt <= cnt+1; one round key per cycle.
REQ-018 rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (in bits [31:24] of the round constant word).
REQ-019 On the edge writing rk[10]: state <= READY, keys_valid <= 1; keys_valid first high 10 cycles after the accept edge.
REQ-020 busy SHALL equal (state == EXPAND); key_load while busy is ignored with no side effect.
REQ-021 A load accepted in READY SHALL restart expansion; keys_valid drops on that same edge.
REQ-022 Read: rd_en=1 sampled on edge T; rd_valid=1 during the cycle after T, for exactly one cycle per request.
REQ-023 If keys_valid=1 and rd_round<=10 at T: rd_key = rk[rd_round], rd_err=0.
REQ-024 If rd_round>10 or keys_valid=0 at T: rd_key = 0, rd_err=1, rd_valid=1.
REQ-025 Simultaneous accepted load and rd_en in READY: read SHALL return pre-load contents (old key set), rd_err=0.
REQ-026 Back-to-back reads SHALL be served every cycle with no bubbles.
REQ-027 rd_key and rd_err SHALL hold their value when rd_valid=0.

Reset
REQ-028 On reset=1 at an edge: state <= IDLE, cnt <= 0, keys_valid/busy/rd_valid/rd_err <= 0, rd_key <= 0.
REQ-029 Reset mid-EXPAND SHALL abort; round-key storage need not be cleared but is unreadable (keys_valid=0).
REQ-030 Reset SHALL take priority over key_load and rd_en in the same cycle.

Structure
REQ-031 Package aes_pkg SHALL hold: KEY_W=128, NUM_ROUNDS=10, RCON table, FSM state encoding.
REQ-032 Sub-module aes_key_round SHALL be combinational: inputs prev_key[127:0], rcon[7:0]; output next_key (RotWord, 4x S-box SubWord, XOR chain).
REQ-033 Round-key storage SHALL be an 11x128 register array inside aes_key_sched_ctrl.

Verification
REQ-034 Load 2b7e151628aed2a6abf7158809cf4f3c -> keys_valid high 10 cycles after accept; read round 1 = a0fafe1788542cb123a339392a6c7605.
REQ-035 Same key, read rounds 0 and 10 back-to-back -> 2b7e1516...4f3c then d014f9a8c9ee2589e13f0cc8b6630ca6, consecutive rd_valid cycles.
REQ-036 rd_round=11 in READY -> rd_valid=1, rd_err=1, rd_key=0; read during EXPAND -> rd_err=1.
REQ-037 key_load pulsed at cycle 3 of EXPAND with key 000...0 -> ignored; final round 10 still d014f9a8...0ca6.
REQ-038 Reset asserted at cycle 5 of EXPAND -> next cycle state IDLE, busy=0, keys_valid=0; new load then expands correctly.
REQ-039 In READY, load key 00..00 with simultaneous read round 10 -> rd_key=d014f9a8...0ca6, keys_valid low; after re-expansion round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
